vec_mem_host_ctrl: RTL and testbench
====================================

# vec_mem_host_ctrl

Host-side controller and responder for the vector CPU's data-memory port. It owns the vector data memory (DEPTH words of R lanes × N bits) and serves the CPU's load/store port. It also gives an external host a request/acknowledge port for preloading operands and reading back results, and sequences a run: it raises `start`, waits for `EndFlag`, and counts cycles. Host access and CPU execution are mutually exclusive, and a small state machine enforces this.

## Interface
Parameters:
- `I`, 32, CPU address width
- `N`, 8, lane width in bits
- `R`, 6, lanes per vector word
- `DEPTH`, 256, vector words in memory (power of two); `AW = $clog2(DEPTH)`
- `TIMEOUT`, 4096, watchdog limit in RUN cycles (used only with `VEC_MEM_TIMEOUT_EN`)

Ports:
- `clk` in 1, single clock; all state changes on the rising edge
- `reset` in 1, asynchronous, active-high
- `MemWriteM` in 1, CPU store enable
- `Address` in I, CPU vector-word address; bits [AW-1:0] used, upper bits ignored (wraps modulo DEPTH)
- `WriteData` in [R-1:0][N-1:0], CPU store data
- `ReadData` out [R-1:0][N-1:0], CPU load data
- `EndFlag` in 1, CPU program-complete flag
- `start` out 1, CPU run enable (level)
- `host_go` in 1, request a run
- `host_req` in 1, host access request (level, held until ack)
- `host_we` in 1, host write (1) / read (0)
- `host_addr` in AW, host vector-word address
- `host_wd` in [R-1:0][N-1:0], host write data
- `host_ack` out 1, one-cycle access-complete pulse
- `host_rd` out [R-1:0][N-1:0], host read data, valid while `host_ack`=1
- `busy` out 1, state==RUN
- `done` out 1, state==DONE
- `run_cycles` out 32, RUN cycle count of the last/current run
- `timeout` out 1, last run ended by watchdog

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN: `host_go`=1 and no host transaction is pending (`host_req`=0 and `host_ack`=0). This clears `run_cycles` and `timeout`.
- RUN → DONE: `EndFlag`=1 sampled.
- DONE → RUN: same condition as IDLE → RUN. DONE never returns to IDLE except by reset.
- `start` = 1 exactly while in RUN.
- CPU port:
  - `ReadData` = mem[`Address`[AW-1:0]], combinational, in every state.
  - The memory is written with `WriteData` at the edge only when state==RUN and `MemWriteM`=1. CPU writes outside RUN are ignored.
- Host port, served only in IDLE and DONE:
  - At an edge where `host_req`=1 and `host_ack`=0, the access is performed: a write updates mem[`host_addr`] with `host_wd`; a read captures mem[`host_addr`] into `host_rd`.
  - `host_ack`=1 for the following cycle, then 0. The host deasserts `host_req` or presents a new request after the ack, so the peak rate is one access per 2 cycles.
  - A `host_req` asserted during RUN is stalled with no ack until DONE.
- `host_rd` holds its last captured value between reads.
- `run_cycles` increments on every edge in RUN, including the edge that samples `EndFlag`, and saturates at 2^32−1.
- Memory contents are not cleared by reset. `reset` mid-run aborts immediately to IDLE.

## Timing
- Reset values:
  - state IDLE
  - `start`, `busy`, `done`, `host_ack`, `timeout` = 0
  - `host_rd` = 0
  - `run_cycles` = 0
- `host_go` sampled at edge t → `start`=1 from t onward.
- `EndFlag` sampled at edge t → `start`=0 and `done`=1 from t onward.
- Host access latency: 1 cycle from request sampling to `host_ack`.
- CPU read latency: 0 cycles (combinational). CPU write becomes visible to reads after the writing edge.
- Simultaneous events:
  - `host_go` with `host_req` pending: the host access wins and the go is ignored, so the host must re-assert it.
  - `EndFlag` with a pending `host_req` in RUN: the access is served starting from DONE (ack one cycle after entering DONE).

## Configuration
- `VEC_MEM_TIMEOUT_EN` defined:
  - In RUN, when `run_cycles` reaches `TIMEOUT` without `EndFlag`, the next state is DONE and `timeout`=1.
  - If `EndFlag` and the limit occur together, `EndFlag` wins and `timeout`=0.
- `VEC_MEM_TIMEOUT_EN` undefined: `timeout` is tied to 0, the `TIMEOUT` parameter is unused, and RUN lasts until `EndFlag`.

## Test plan
- Reset: assert `reset` mid-RUN → all outputs at their reset values asynchronously; state IDLE after release.
- Host write then read: write addr 3 lanes {6,5,4,3,2,1} → `host_ack` 1 cycle later. Read addr 3 → `host_rd`={6,5,4,3,2,1} with `host_ack`. `ReadData` with `Address`=3 shows the same value.
- Run length: `host_go`, `EndFlag` high during the 10th RUN cycle → `done`=1, `start`=0, `run_cycles`=10.
- CPU store: in RUN, `MemWriteM`=1, `Address`=0x105, data all 0xAA → after DONE, a host read of addr 5 returns 0xAA×6 (wrap). The same store attempted in IDLE leaves memory unchanged.
- Stall and priority:
  - `host_req` held during RUN → no ack until DONE, then ack 1 cycle after entering DONE.
  - `host_go` with `host_req`=1 in IDLE → the access is served and the state stays IDLE.
- Watchdog (macro on, `TIMEOUT`=16): `EndFlag` never asserted → DONE with `timeout`=1 and `run_cycles`=16. With the macro off, the block is still in RUN after 100 cycles.

Source files
------------

// File: rtl/vec_mem_host_ctrl.sv
// rtl/vec_mem_host_ctrl.sv - vector data memory with CPU load/store port, host access port and run sequencer
// Optional run watchdog enabled by defining VEC_MEM_TIMEOUT_EN.
module vec_mem_host_ctrl #(
  parameter int I       = 32,
  parameter int N       = 8,
  parameter int R       = 6,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4096,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic [I-1:0]          Address,
  input  logic [R-1:0][N-1:0]   WriteData,
  output logic [R-1:0][N-1:0]   ReadData,
  input  logic                  EndFlag,
  output logic                  start,
  input  logic                  host_go,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [R-1:0][N-1:0]   host_wd,
  output logic                  host_ack,
  output logic [R-1:0][N-1:0]   host_rd,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           run_cycles,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [31:0]           run_cycles_q, run_cycles_d;
  logic                  timeout_q, timeout_d;
  logic                  host_ack_q, host_ack_d;
  logic [R-1:0][N-1:0]   host_rd_q, host_rd_d;
  logic [R-1:0][N-1:0]   mem [DEPTH];

  logic [AW-1:0]         cpu_addr;
  logic                  go_ok;
  logic                  host_fire;

  assign cpu_addr  = Address[AW-1:0];
  // A pending or just-acknowledged host access blocks a run request.
  assign go_ok     = host_go && !host_req && !host_ack_q;
  assign host_fire = (state_q != RUN) && host_req && !host_ack_q;

`ifndef VEC_MEM_TIMEOUT_EN
  localparam int unused_timeout_limit = TIMEOUT;
`endif
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[I-1:AW];

  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    host_ack_d   = host_fire;
    host_rd_d    = host_rd_q;
    if (host_fire && !host_we) host_rd_d = mem[host_addr];
    case (state_q)
      IDLE, DONE: begin
        if (go_ok) begin
          state_d      = RUN;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
        end
      end
      RUN: begin
        if (run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
        if (EndFlag) begin
          state_d = DONE;
        end
`ifdef VEC_MEM_TIMEOUT_EN
        // This edge brings the count up to the limit.
        else if (run_cycles_q >= 32'(TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      host_ack_q   <= host_ack_d;
      host_rd_q    <= host_rd_d;
    end
  end

  // CPU and host writes are mutually exclusive by state, so one write port suffices.
  always_ff @(posedge clk) begin
    if (state_q == RUN && MemWriteM) mem[cpu_addr] <= WriteData;
    else if (host_fire && host_we) mem[host_addr] <= host_wd;
  end

  assign ReadData   = mem[cpu_addr];
  assign start      = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign host_ack   = host_ack_q;
  assign host_rd    = host_rd_q;
  assign run_cycles = run_cycles_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_vec_mem_host_ctrl.sv
// tb/tb_vec_mem_host_ctrl.sv - randomized self-checking bench for vec_mem_host_ctrl
// Watchdog checks follow VEC_MEM_TIMEOUT_EN.
module tb_vec_mem_host_ctrl;

  localparam int W = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWriteM = 1'b0;
  logic [31:0]   Address = '0;
  logic [W-1:0]  WriteData = '0;
  logic [W-1:0]  ReadData;
  logic          EndFlag = 1'b0;
  logic          start;
  logic          host_go = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [7:0]    host_addr = '0;
  logic [W-1:0]  host_wd = '0;
  logic          host_ack;
  logic [W-1:0]  host_rd;
  logic          busy;
  logic          done;
  logic [31:0]   run_cycles;
  logic          timeout;

  logic [W-1:0]  mdl [256];
  int            n_cmp = 0;
  int            n_bad = 0;

  vec_mem_host_ctrl #(.I(32), .N(8), .R(6), .DEPTH(256), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .EndFlag(EndFlag), .start(start),
    .host_go(host_go), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wd(host_wd), .host_ack(host_ack), .host_rd(host_rd), .busy(busy),
    .done(done), .run_cycles(run_cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic host_access(input bit we, input logic [7:0] a, input logic [W-1:0] wd, input bit check);
    host_req = 1'b1; host_we = we; host_addr = a; host_wd = wd;
    tick();
    if (check) chk("host_ack_pulse", 64'(host_ack), 64'd1);
    if (!we) chk("host_rd", 64'(host_rd), 64'(mdl[a]));
    if (we) mdl[a] = wd;
    host_req = 1'b0;
    tick();
    if (check) chk("host_ack_low", 64'(host_ack), 64'd0);
  endtask

  task automatic run_prog(input int len, input bit stores);
    logic [W-1:0] d;
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    chk("start_on_go", 64'(start), 64'd1);
    for (int i = 1; i <= len; i++) begin
      EndFlag = (i == len);
      MemWriteM = 1'b0;
      if (stores && $urandom_range(0, 1) == 1) begin
        d = rnd_word();
        MemWriteM = 1'b1;
        Address = $urandom;
        WriteData = d;
        mdl[Address[7:0]] = d;
      end
      tick();
    end
    EndFlag = 1'b0;
    MemWriteM = 1'b0;
    chk("done_after_end", 64'(done), 64'd1);
    chk("start_after_end", 64'(start), 64'd0);
    chk("run_cycles", 64'(run_cycles), 64'(len));
  endtask

  initial begin
    logic [7:0] a;
    int len;

    #12;
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_host_rd", 64'(host_rd), 64'd0);
    chk("rst_run_cycles", 64'(run_cycles), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) host_access(1'b1, 8'(i), rnd_word(), 1'b0);

    host_access(1'b1, 8'd3, 48'h060504030201, 1'b1);
    host_access(1'b0, 8'd3, '0, 1'b1);
    Address = 32'd3;
    #1;
    chk("cpu_read_addr3", 64'(ReadData), 64'h060504030201);

    MemWriteM = 1'b1; Address = 32'h105; WriteData = {6{8'hAA}};
    tick();
    MemWriteM = 1'b0;
    host_access(1'b0, 8'd5, '0, 1'b0);

    run_prog(10, 1'b0);
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    MemWriteM = 1'b1; Address = 32'h105; WriteData = {6{8'hAA}};
    EndFlag = 1'b1;
    tick();
    MemWriteM = 1'b0; EndFlag = 1'b0;
    mdl[5] = {6{8'hAA}};
    host_access(1'b0, 8'd5, '0, 1'b1);

    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_no_ack", 64'(host_ack), 64'd0);
    end
    EndFlag = 1'b1;
    tick();
    EndFlag = 1'b0;
    chk("stall_enter_done", 64'(done), 64'd1);
    chk("stall_ack_at_done", 64'(host_ack), 64'd0);
    tick();
    chk("stall_ack_after_done", 64'(host_ack), 64'd1);
    chk("stall_rd", 64'(host_rd), 64'(mdl[3]));
    host_req = 1'b0;
    tick();

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 3; k++) host_access(1'b1, 8'($urandom), rnd_word(), 1'b0);
      len = $urandom_range(1, 20);
      run_prog(len, 1'b1);
      for (int k = 0; k < 3; k++) begin
        a = 8'($urandom);
        host_access(1'b0, a, '0, 1'b0);
        Address = {$urandom_range(0, 15), 20'h0, 4'h0, a};
        #1;
        chk("cpu_read_rand", 64'(ReadData), 64'(mdl[a]));
      end
    end

    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_idle_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    host_go = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    tick();
    host_go = 1'b0; host_req = 1'b0;
    chk("go_vs_req_ack", 64'(host_ack), 64'd1);
    chk("go_vs_req_idle", 64'(busy), 64'd0);
    chk("go_vs_req_rd", 64'(host_rd), 64'(mdl[3]));
    tick();

    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_start", 64'(start), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_run_cycles", 64'(run_cycles), 64'd0);
    chk("abort_host_rd", 64'(host_rd), 64'd0);
    chk("abort_timeout", 64'(timeout), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    host_go = 1'b1;
    tick();
    host_go = 1'b0;
`ifdef VEC_MEM_TIMEOUT_EN
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    chk("wd_done", 64'(done), 64'd1);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_run_cycles", 64'(run_cycles), 64'd16);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("nowd_busy", 64'(busy), 64'd1);
    chk("nowd_run_cycles", 64'(run_cycles), 64'd100);
    chk("nowd_timeout", 64'(timeout), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
